// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART TX arbiter slice and the RX-side arbiters
//   that reuse the round-robin picker.
//   Contents:
//     UART_WORD_LENGTH  default data bits per frame (matches UART TX block)
//     ST_IDLE/ST_SEND/ST_WAIT/ST_DONE  binary FSM state encodings
//     clog2()           pointer-width helper, never returns less than 1
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_WORD_LENGTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Width needed to hold an index 0..n-1; a single requester still gets 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the producer handshake and the UART TX hand-off of the arbiter.
//   Signals:
//     req, req_data      producer requests and their bytes
//     ack, done          per-producer grant / frame-complete pulses
//     tx_data, transmit  byte and start pulse towards the UART TX serializer
//     tx_flag            frame-done pulse from the UART TX serializer
//     busy, tx_timeout   arbiter status
//   Modports:
//     master  producers plus UART TX side (drive req/req_data/tx_flag)
//     slave   the arbiter itself
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int WORD_LENGTH = 8
) ();

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             done;
  logic [WORD_LENGTH-1:0]         tx_data;
  logic                           transmit;
  logic                           tx_flag;
  logic                           busy;
  logic                           tx_timeout;

  modport master (
    output req, req_data, tx_flag,
    input  ack, done, tx_data, transmit, busy, tx_timeout
  );

  modport slave (
    input  req, req_data, tx_flag,
    output ack, done, tx_data, transmit, busy, tx_timeout
  );

endinterface

// File: rtl/uart_rr_picker.sv
// ---------------------------------------------------------------------------
// uart_rr_picker
//   Combinational round-robin selector: returns the first asserted request
//   found scanning rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
//   Ports:
//     req      in   NUM_REQ  request vector
//     rr_ptr   in   PTR_W    highest-priority index this round
//     winner   out  PTR_W    selected index (0 when no request)
//     any_req  out  1        at least one request asserted
// ---------------------------------------------------------------------------
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  int               idx_s;
  logic [PTR_W-1:0] cand_s;

  // Scan from the farthest offset back to rr_ptr so the nearest hit is kept.
  always_comb begin
    winner  = '0;
    idx_s   = 0;
    cand_s  = '0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s = int'(rr_ptr) + i;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      cand_s = PTR_W'(idx_s);
      if (req[cand_s]) begin
        winner = cand_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX serializer among NUM_REQ byte producers. Round-robin
//   grant, latches the winner's byte, pulses transmit, holds tx_data until
//   the serializer reports frame done on tx_flag.
//   Ports:
//     clk     in  system clock, posedge
//     reset   in  synchronous active-high, clears all state
//     bus     slave modport of uart_tx_arbiter_if (req/req_data/ack/done,
//             tx_data/transmit/tx_flag, busy/tx_timeout)
//   Optional feature:
//     UART_TX_ARB_TIMEOUT_EN  WAIT watchdog of TIMEOUT_CYCLES cycles; when
//                             undefined WAIT is unbounded and tx_timeout is 0.
//   All outputs are registers, so no pulse can appear in a reset cycle.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int WORD_LENGTH    = UART_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int PTR_W = clog2(NUM_REQ);

  logic [1:0]             state_r;
  logic [1:0]             state_s;
  logic [PTR_W-1:0]       rr_ptr_r;
  logic [PTR_W-1:0]       owner_r;
  logic [PTR_W-1:0]       winner_s;
  logic [PTR_W-1:0]       next_ptr_s;
  logic                   any_req_s;
  logic                   grant_s;
  logic                   finish_s;
  logic                   abort_s;
  logic [WORD_LENGTH-1:0] tx_data_r;
  logic [NUM_REQ-1:0]     ack_r;
  logic [NUM_REQ-1:0]     done_r;
  logic                   transmit_r;
  logic                   busy_r;
  logic                   tx_timeout_r;
  logic [WORD_LENGTH-1:0] data_arr_s [NUM_REQ];

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr_s[g] = bus.req_data[g*WORD_LENGTH +: WORD_LENGTH];
  end

  assign grant_s  = (state_r == ST_IDLE) && any_req_s;
  assign finish_s = (state_r == ST_WAIT) && bus.tx_flag;

  // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
  assign next_ptr_s = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0 : owner_r + PTR_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMR_W = clog2(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_r;

  // WAIT dwell counter, restarted on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= '0;
    end else if (state_r != ST_WAIT) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // A tx_flag on the terminal cycle takes precedence over the abort.
  assign abort_s = (state_r == ST_WAIT) && !bus.tx_flag &&
                   (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;

  // Keeps the watchdog length parameter referenced when the watchdog is absent.
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  assign abort_s          = 1'b0;
`endif

  // Next-state decode; tx_flag is only meaningful in WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: state_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_flag) begin
          state_s = ST_DONE;
        end else if (abort_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Owner and byte captured at grant; held until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r   <= '0;
      tx_data_r <= '0;
    end else if (grant_s) begin
      owner_r   <= winner_s;
      tx_data_r <= data_arr_s[winner_s];
    end
  end

  // Round-robin pointer moves past the owner once its frame ends or aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if ((state_r == ST_DONE) || abort_s) begin
      rr_ptr_r <= next_ptr_s;
    end
  end

  // Registered pulses and status, aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r        <= '0;
      done_r       <= '0;
      transmit_r   <= 1'b0;
      busy_r       <= 1'b0;
      tx_timeout_r <= 1'b0;
    end else begin
      ack_r        <= '0;
      done_r       <= '0;
      transmit_r   <= grant_s;
      busy_r       <= (state_s != ST_IDLE);
      tx_timeout_r <= abort_s;
      if (grant_s) begin
        ack_r[winner_s] <= 1'b1;
      end
      if (finish_s) begin
        done_r[owner_r] <= 1'b1;
      end
    end
  end

  assign bus.ack        = ack_r;
  assign bus.done       = done_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.transmit   = transmit_r;
  assign bus.busy       = busy_r;
  assign bus.tx_timeout = tx_timeout_r;

endmodule
